// File: rtl/iot_stream_sched.sv
// iot_stream_sched: round-robin front end for the IoT data filter.
// Grants one of N_SRC sensor sources, captures its 128-bit sample and
// streams it MSB-first as 16 byte beats, stalling while the filter is busy.
// fn_sel is held for a whole run of SAMPLES_PER_ROUND x NUM_ROUNDS samples.
module iot_stream_sched #(
  parameter int N_SRC             = 4,
  parameter int SAMPLES_PER_ROUND = 8,
  parameter int NUM_ROUNDS        = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             cfg_fn_sel,
  input  logic [N_SRC-1:0]       src_req,
  input  logic [N_SRC*128-1:0]   src_data,
  output logic [N_SRC-1:0]       src_ack,
  input  logic                   filt_busy,
  output logic                   in_en,
  output logic [7:0]             iot_in,
  output logic [2:0]             fn_sel,
  output logic [3:0]             round_idx,
  output logic [2:0]             grant_id,
  output logic                   done
);

  localparam int SC_W = (SAMPLES_PER_ROUND > 1) ? $clog2(SAMPLES_PER_ROUND) : 1;
  localparam logic [SC_W-1:0] SC_LAST    = SC_W'(SAMPLES_PER_ROUND - 1);
  localparam logic [3:0]      ROUND_LAST = 4'(NUM_ROUNDS - 1);
  // Last-granted index after reset points at the top source so source 0 wins first.
  localparam logic [2:0]      GRANT_RST  = 3'(N_SRC - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARB  = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [127:0]     shreg;
  logic [3:0]       byte_cnt;
  logic [SC_W-1:0]  sample_cnt;

  logic             pick_valid;
  logic [2:0]       pick_idx;
  logic [N_SRC-1:0] pick_onehot;
  logic [127:0]     pick_data;

  // Round-robin pick: nearest requester above the last grant, wrapping at N_SRC.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    pick_valid  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    pick_data   = '0;
    // Walk distances from farthest to nearest; the nearest match is written last and wins.
    for (int k = N_SRC; k >= 1; k--) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (src_req[i] && ((int'(grant_id) + k) % N_SRC == i)) begin
          pick_valid  = 1'b1;
          pick_idx    = 3'(i);
          pick_onehot = '0;
          pick_onehot[i] = 1'b1;
          pick_data   = src_data[128*i +: 128];
        end
      end
    end
  end

  // Scheduler FSM: arbitration, byte serialisation and sample/round accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values regardless of statement order.
      state      <= IDLE;
      shreg      <= '0;
      byte_cnt   <= '0;
      sample_cnt <= '0;
      src_ack    <= '0;
      in_en      <= 1'b0;
      iot_in     <= '0;
      fn_sel     <= '0;
      round_idx  <= '0;
      grant_id   <= GRANT_RST;
      done       <= 1'b0;
    end else begin
      src_ack <= '0;
      in_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            fn_sel     <= cfg_fn_sel;
            sample_cnt <= '0;
            round_idx  <= '0;
            state      <= ARB;
          end
        end
        ARB: begin
          if (pick_valid) begin
            shreg    <= pick_data;
            src_ack  <= pick_onehot;
            grant_id <= pick_idx;
            byte_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (!filt_busy) begin
            in_en    <= 1'b1;
            iot_in   <= shreg[127:120];
            shreg    <= {shreg[119:0], 8'h00};
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) begin
              if (sample_cnt == SC_LAST) begin
                sample_cnt <= '0;
                if (round_idx == ROUND_LAST) begin
                  done  <= 1'b1;
                  state <= DONE;
                end else begin
                  round_idx <= round_idx + 4'd1;
                  state     <= ARB;
                end
              end else begin
                sample_cnt <= sample_cnt + SC_W'(1);
                state      <= ARB;
              end
            end
          end
        end
        DONE: begin
          if (start) begin
            done       <= 1'b0;
            fn_sel     <= cfg_fn_sel;
            sample_cnt <= '0;
            round_idx  <= '0;
            state      <= ARB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iot_stream_sched.sv
// Self-checking bench for iot_stream_sched: a negedge monitor pops expected
// grants and bytes from scoreboard queues filled as stimulus is driven.
module tb_iot_stream_sched;

  localparam int N_SRC = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [2:0]           cfg_fn_sel;
  logic [N_SRC-1:0]     src_req;
  logic [N_SRC*128-1:0] src_data;
  logic [N_SRC-1:0]     src_ack;
  logic                 filt_busy;
  logic                 in_en;
  logic [7:0]           iot_in;
  logic [2:0]           fn_sel;
  logic [3:0]           round_idx;
  logic [2:0]           grant_id;
  logic                 done;

  int n_cmp = 0;
  int n_err = 0;

  int         exp_grant[$];
  logic [7:0] exp_byte[$];

  typedef struct {
    logic [3:0] req;
    int         grant;
  } rr_vec_t;

  int           mon_g;
  logic [127:0] mon_w;
  logic [7:0]   mon_b;

  always #5 clk = ~clk;

  iot_stream_sched #(.N_SRC(N_SRC), .SAMPLES_PER_ROUND(8), .NUM_ROUNDS(12)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_fn_sel(cfg_fn_sel),
    .src_req(src_req), .src_data(src_data), .src_ack(src_ack),
    .filt_busy(filt_busy), .in_en(in_en), .iot_in(iot_in), .fn_sel(fn_sel),
    .round_idx(round_idx), .grant_id(grant_id), .done(done)
  );

  function automatic logic [127:0] word_of(int i);
    logic [127:0] base;
    base = 128'h00112233445566778899AABBCCDDEEFF;
    return base ^ {16{8'(i * 17)}};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each ack must match the next expected grant and
  // queues that source's 16 bytes; each beat must match the next byte.
  always @(negedge clk) begin
    if (src_ack != '0) begin
      if (exp_grant.size() == 0) begin
        check("unexpected_ack", 128'(src_ack), 128'(0));
      end else begin
        mon_g = exp_grant.pop_front();
        check("ack_onehot", 128'(src_ack), 128'(1) << mon_g);
        check("ack_grant_id", 128'(grant_id), 128'(mon_g));
        mon_w = word_of(mon_g);
        for (int b = 0; b < 16; b++) exp_byte.push_back(mon_w[127-8*b -: 8]);
      end
    end
    if (in_en === 1'b1) begin
      if (exp_byte.size() == 0) begin
        check("unexpected_beat", 128'(iot_in), 128'(0));
      end else begin
        mon_b = exp_byte.pop_front();
        check("beat_byte", 128'(iot_in), 128'(mon_b));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; src_req = '0; filt_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_grant.delete();
    exp_byte.delete();
  endtask

  task automatic pulse_start(input logic [2:0] f);
    cfg_fn_sel = f;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (src_ack == '0 && t < 60);
    check({name, "_ack_seen"}, 128'(src_ack != '0), 128'(1));
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_byte.size() != 0 || exp_grant.size() != 0) && t < 80) begin
      tick();
      t++;
    end
    check(name, 128'(exp_byte.size() + exp_grant.size()), 128'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_src_ack"},   128'(src_ack),   128'(0));
    check({tag, "_in_en"},     128'(in_en),     128'(0));
    check({tag, "_iot_in"},    128'(iot_in),    128'(0));
    check({tag, "_fn_sel"},    128'(fn_sel),    128'(0));
    check({tag, "_round_idx"}, 128'(round_idx), 128'(0));
    check({tag, "_grant_id"},  128'(grant_id),  128'(N_SRC - 1));
    check({tag, "_done"},      128'(done),      128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_vec_t tbl[14];
    int beats, n, acks;

    tbl = '{
      '{4'b1111, 0}, '{4'b1111, 1}, '{4'b1111, 2}, '{4'b1111, 3}, '{4'b1111, 0},
      '{4'b1011, 1}, '{4'b1011, 3}, '{4'b1011, 0}, '{4'b0100, 2}, '{4'b0101, 0},
      '{4'b1000, 3}, '{4'b0011, 0}, '{4'b0110, 1}, '{4'b0110, 2}
    };
    for (int i = 0; i < N_SRC; i++) src_data[128*i +: 128] = word_of(i);
    cfg_fn_sel = 3'b000;

    // Reset state
    do_reset();
    check_reset_values("reset");

    // Single source: ack, 16 back-to-back beats, one gap cycle carrying the next ack
    pulse_start(3'b101);
    check("single_fn_sel", 128'(fn_sel), 128'(5));
    src_req = 4'b0001;
    exp_grant.push_back(0);
    exp_grant.push_back(0);
    wait_ack("single");
    for (int b = 0; b < 16; b++) begin
      tick();
      check("single_beat_en", 128'(in_en), 128'(1));
    end
    tick();
    check("single_gap_en", 128'(in_en), 128'(0));
    check("single_gap_ack", 128'(src_ack), 128'(4'b0001));
    src_req = '0;
    drain("single_drain");

    // Round-robin table: request pattern per sample and the grant it must produce
    do_reset();
    pulse_start(3'b000);
    for (int j = 0; j < 14; j++) begin
      src_req = tbl[j].req;
      exp_grant.push_back(tbl[j].grant);
      wait_ack("rr");
      check("rr_grant_id", 128'(grant_id), 128'(tbl[j].grant));
    end
    src_req = '0;
    drain("rr_drain");

    // Stall for 3 cycles after the 5th beat
    do_reset();
    pulse_start(3'b001);
    src_req = 4'b0001;
    exp_grant.push_back(0);
    wait_ack("stall");
    src_req = '0;
    beats = 0;
    n = 0;
    while (beats < 5 && n < 40) begin
      tick();
      n++;
      if (in_en) beats++;
    end
    check("stall_five_beats", 128'(beats), 128'(5));
    filt_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_en_low", 128'(in_en), 128'(0));
    end
    filt_busy = 1'b0;
    tick();
    check("stall_resume_en", 128'(in_en), 128'(1));
    check("stall_sixth_byte", 128'(iot_in), 128'(8'h55));
    drain("stall_drain");

    // Start during SEND is ignored
    do_reset();
    pulse_start(3'b010);
    src_req = 4'b0001;
    exp_grant.push_back(0);
    wait_ack("ign");
    src_req = '0;
    tick(); tick();
    cfg_fn_sel = 3'b111;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_fn_sel", 128'(fn_sel), 128'(3'b010));
    check("ign_done", 128'(done), 128'(0));
    drain("ign_drain");
    check("ign_fn_sel_after", 128'(fn_sel), 128'(3'b010));

    // Reset after the 7th beat drops the rest of the sample
    do_reset();
    pulse_start(3'b100);
    src_req = 4'b0001;
    exp_grant.push_back(0);
    wait_ack("midrst");
    beats = 0;
    n = 0;
    while (beats < 7 && n < 40) begin
      tick();
      n++;
      if (in_en) beats++;
    end
    rst = 1'b1;
    tick();
    check_reset_values("midrst");
    check("midrst_bytes_left", 128'(exp_byte.size()), 128'(9));
    exp_byte.delete();
    // start together with rst: rst wins, so the block stays idle
    start = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("midrst_no_ack", 128'(src_ack), 128'(0));
    end
    src_req = 4'b1111;
    exp_grant.push_back(0);
    pulse_start(3'b100);
    wait_ack("midrst_restart");
    check("midrst_first_grant", 128'(grant_id), 128'(0));
    src_req = '0;
    drain("midrst_drain");

    // Full unstalled run: 96 samples, round steps every 8, done after 1632 cycles
    do_reset();
    src_req = 4'b1111;
    for (int s = 0; s < 96; s++) exp_grant.push_back(s % 4);
    pulse_start(3'b011);
    n = 0;
    acks = 0;
    while (done !== 1'b1 && n < 2000) begin
      tick();
      n++;
      if (src_ack != '0) begin
        check("run_round_at_ack", 128'(round_idx), 128'(acks / 8));
        acks++;
      end
    end
    check("run_cycles", 128'(n), 128'(1632));
    check("run_acks", 128'(acks), 128'(96));
    check("run_done", 128'(done), 128'(1));
    check("run_round_final", 128'(round_idx), 128'(11));
    check("run_fn_sel", 128'(fn_sel), 128'(3'b011));
    for (int c = 0; c < 20; c++) begin
      tick();
      check("run_idle_en", 128'(in_en), 128'(0));
    end
    check("run_queues_empty", 128'(exp_byte.size() + exp_grant.size()), 128'(0));
    // Restart from DONE with a new function select
    exp_grant.push_back(0);
    pulse_start(3'b110);
    check("restart_done", 128'(done), 128'(0));
    check("restart_fn_sel", 128'(fn_sel), 128'(3'b110));
    check("restart_round", 128'(round_idx), 128'(0));
    wait_ack("restart");
    src_req = '0;
    drain("restart_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
